// File: rtl/calc_btn_driver.sv
// rtl/calc_btn_driver.sv - replays calculator button levels and a btnc strobe for a requested ALU opcode
// Optional 2-entry command FIFO enabled by defining CALC_BTN_QUEUE_EN.
module calc_btn_driver #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  input  logic [3:0] op_code,
  output logic       op_ready,
  output logic       btnl,
  output logic       btnr,
  output logic       btnd,
  output logic       btnc,
  output logic       done,
  output logic       err
);

  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_GAP,
    S_REJECT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      btn_code_q, btn_code_d;

  logic            op_ready_q, op_ready_d;
  logic [2:0]      btn_q, btn_d;
  logic            btnc_q, btnc_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            cmd_take;
  logic [3:0]      cmd_code;
  logic [3:0]      cmd_dec;

  // Returns {valid, btnl, btnr, btnd}.
  function automatic logic [3:0] decode_op(input logic [3:0] code);
    logic [3:0] r;
    case (code)
      4'h0:    r = 4'b1_000;
      4'h1:    r = 4'b1_001;
      4'h4:    r = 4'b1_010;
      4'h5:    r = 4'b1_011;
      4'h6:    r = 4'b1_100;
      4'hA:    r = 4'b1_101;
      4'hB:    r = 4'b1_110;
      4'hC:    r = 4'b1_111;
      default: r = 4'b0_000;
    endcase
    return r;
  endfunction

`ifdef CALC_BTN_QUEUE_EN
  logic [3:0] fifo0_q, fifo0_d;
  logic [3:0] fifo1_q, fifo1_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  always_comb begin
    push      = op_valid & op_ready_q;
    pop       = (state_q == S_IDLE) && (count_q != 2'd0);
    cmd_take  = pop;
    cmd_code  = rd_ptr_q ? fifo1_q : fifo0_q;
    fifo0_d   = fifo0_q;
    fifo1_d   = fifo1_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push) begin
      if (wr_ptr_q) fifo1_d = op_code;
      else          fifo0_d = op_code;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    op_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo0_q  <= 4'd0;
      fifo1_q  <= 4'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      fifo0_q  <= fifo0_d;
      fifo1_q  <= fifo1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`else
  always_comb begin
    cmd_take   = op_valid & op_ready_q;
    cmd_code   = op_code;
    op_ready_d = (state_d == S_IDLE);
  end
`endif

  assign cmd_dec = decode_op(cmd_code);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      btn_code_q <= 3'b000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_code_q <= btn_code_d;
    end
  end

  // Next state: each timed phase loads the shared counter with its length minus one.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    btn_code_d = btn_code_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_take) begin
          if (cmd_dec[3]) begin
            state_d    = S_SETUP;
            cnt_d      = CW'(SETUP_CYC - 1);
            btn_code_d = cmd_dec[2:0];
          end else begin
            state_d    = S_REJECT;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = CW'(PULSE_CYC - 1);
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CW'(GAP_CYC - 1);
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
        end
      end
      S_REJECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the upcoming state so they can be registered without extra latency.
  always_comb begin
    btn_d  = 3'b000;
    btnc_d = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_d)
      S_SETUP, S_HOLD: btn_d = btn_code_d;
      S_STROBE: begin
        btn_d  = btn_code_d;
        btnc_d = 1'b1;
      end
      S_REJECT: err_d = 1'b1;
      default: ;
    endcase
    done_d = (state_q == S_GAP) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_ready_q <= 1'b1;
      btn_q      <= 3'b000;
      btnc_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      op_ready_q <= op_ready_d;
      btn_q      <= btn_d;
      btnc_q     <= btnc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign op_ready = op_ready_q;
  assign btnl     = btn_q[2];
  assign btnr     = btn_q[1];
  assign btnd     = btn_q[0];
  assign btnc     = btnc_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
